// File: rtl/mdu_if.sv
// Handshake and result bundle between the execute stage and the multiply/divide unit.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, output op, output rs_data, output rt_data,
                    input busy, input hi, input lo);
    modport slave  (input start, input op, input rs_data, input rt_data,
                    output busy, output hi, output lo);
endinterface

// File: rtl/mdu.sv
// MIPS multiply/divide unit: owns HI/LO and runs MULT/DIV as fixed-latency operations.
// state | meaning
// IDLE  | no operation in flight; start is accepted, busy=0
// RUN   | result pending, counter counting down, busy=1
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        pend_q, pend_d;
    logic               pend_wr_q, pend_wr_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [31:0] op_a, op_b;
    logic [63:0] prod_s, prod_u;
    logic        div_signed, neg_a, neg_b;
    logic [31:0] abs_a, abs_b, div_b, q_mag, r_mag, quot, rem;

    assign op_a = bus.rs_data;
    assign op_b = bus.rt_data;

    always_comb begin
        prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        prod_u = {32'b0, op_a} * {32'b0, op_b};
    end

    // Divide on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow.
    always_comb begin
        div_signed = (bus.op == OP_DIV);
        neg_a      = div_signed & op_a[31];
        neg_b      = div_signed & op_b[31];
        abs_a      = neg_a ? (32'd0 - op_a) : op_a;
        abs_b      = neg_b ? (32'd0 - op_b) : op_b;
        div_b      = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag      = abs_a / div_b;
        r_mag      = abs_a % div_b;
        quot       = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem        = neg_a ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            pend_d    = (bus.op == OP_MULT) ? prod_s : prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_d    = {rem, quot};
                            pend_wr_d = (op_b != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = op_a;
                        OP_MTLO: lo_d = op_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: vector table for single ops plus hand sequences for stalls and reset.
module tb_mdu;
    logic clk;
    logic reset;
    mdu_if bus ();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start   = s;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{"mult_neg",   3'b001, 32'hFFFFFFFF, 32'h00000002,  5, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{"multu",      3'b010, 32'hFFFFFFFF, 32'h00000002,  5, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{"div_neg",    3'b011, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu",       3'b100, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
        vecs[4]  = '{"div_ovf",    3'b011, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"mthi",       3'b101, 32'h12345678, 32'h0000FFFF,  0, 32'h12345678, 32'h80000000};
        vecs[6]  = '{"mtlo",       3'b110, 32'h9ABCDEF0, 32'h0000FFFF,  0, 32'h12345678, 32'h9ABCDEF0};
        vecs[7]  = '{"div_zero",   3'b011, 32'h00000005, 32'h00000000, 10, 32'h12345678, 32'h9ABCDEF0};
        vecs[8]  = '{"nop",        3'b111, 32'h11111111, 32'h22222222,  0, 32'h12345678, 32'h9ABCDEF0};
        vecs[9]  = '{"mult_m3x4",  3'b001, 32'hFFFFFFFD, 32'h00000004,  5, 32'hFFFFFFFF, 32'hFFFFFFF4};
        vecs[10] = '{"div_nn",     3'b011, 32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'h00000003};
        vecs[11] = '{"divu_big",   3'b100, 32'hFFFFFFF9, 32'h00000002, 10, 32'h00000001, 32'h7FFFFFFC};

        drive(1'b0, 3'b000, 32'h0, 32'h0);
        reset = 1'b0;
        #12;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            drive(1'b0, 3'($urandom), $urandom, $urandom);
            cnt = 0;
            while (bus.busy && cnt < 100) begin
                cnt++;
                @(negedge clk);
            end
            chk({vecs[i].name, "_cycles"}, cnt, vecs[i].cyc);
            chk({vecs[i].name, "_hi"}, bus.hi, vecs[i].hi);
            chk({vecs[i].name, "_lo"}, bus.lo, vecs[i].lo);
        end

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        drive(1'b1, 3'b101, 32'hCAFE0001, 32'h0);
        @(negedge clk);
        chk("b2b_mthi_hi", bus.hi, 32'hCAFE0001);
        chk("b2b_mthi_busy", {31'b0, bus.busy}, 32'd0);
        drive(1'b1, 3'b110, 32'hCAFE0002, 32'h0);
        @(negedge clk);
        chk("b2b_mtlo_lo", bus.lo, 32'hCAFE0002);
        chk("b2b_mtlo_hi", bus.hi, 32'hCAFE0001);
        chk("b2b_mtlo_busy", {31'b0, bus.busy}, 32'd0);
        drive(1'b0, 3'b000, 32'h0, 32'h0);

        // starts during RUN and on the completion edge are ignored
        @(negedge clk);
        drive(1'b1, 3'b001, 32'd3, 32'd4);
        @(negedge clk);
        chk("ign_busy_t0", {31'b0, bus.busy}, 32'd1);
        drive(1'b1, 3'b110, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        drive(1'b1, 3'b001, 32'd5, 32'd5);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("ign_busy_t4", {31'b0, bus.busy}, 32'd1);
        chk("ign_lo_t4", bus.lo, 32'hCAFE0002);
        drive(1'b1, 3'b101, 32'h0000AAAA, 32'h0);
        @(negedge clk);
        chk("ign_done_busy", {31'b0, bus.busy}, 32'd0);
        chk("ign_done_hi", bus.hi, 32'h0);
        chk("ign_done_lo", bus.lo, 32'd12);
        @(negedge clk);
        chk("after_done_hi", bus.hi, 32'h0000AAAA);
        chk("after_done_lo", bus.lo, 32'd12);
        drive(1'b0, 3'b000, 32'h0, 32'h0);

        // asynchronous reset mid-RUN discards the in-flight MULT
        @(negedge clk);
        drive(1'b1, 3'b001, 32'd3, 32'd4);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_hi", bus.hi, 32'h0);
        chk("arst_lo", bus.lo, 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("no_late_lo", bus.lo, 32'h0);
            chk("no_late_busy", {31'b0, bus.busy}, 32'd0);
        end

        // op accepted on the very first edge after release
        reset = 1'b0;
        #2;
        reset = 1'b1;
        drive(1'b1, 3'b101, 32'd1, 32'h0);
        @(negedge clk);
        chk("first_edge_hi", bus.hi, 32'd1);
        chk("first_edge_busy", {31'b0, bus.busy}, 32'd0);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit on the execute side of the MIPS datapath. Consumes the two general-register read operands (rs/rt data from the register file) and holds the architectural HI/LO registers. Runs MULT/MULTU/DIV/DIVU as multi-cycle operations and MTHI/MTLO as single-cycle writes. Raises `busy` so the hazard logic can stall HI/LO-dependent instructions.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU (must be ≥1).
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU (must be ≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: issue strobe; `op` and operands are sampled on the rising edge where `start=1`.
- `op` in 3: 3'b001 MULT, 3'b010 MULTU, 3'b011 DIV, 3'b100 DIVU, 3'b101 MTHI, 3'b110 MTLO; all other values are NOP.
- `rs_data` in 32: operand A (multiplicand/dividend, or MTHI/MTLO source).
- `rt_data` in 32: operand B (multiplier/divisor).
- `busy` out 1: a multi-cycle operation is in progress.
- `hi` out 32: architectural HI register.
- `lo` out 32: architectural LO register.

## Operation
- States:
  - IDLE (`busy=0`)
  - RUN (`busy=1`, counter counting down)
- Acceptance:
  - An op is accepted only when `start=1` and state is IDLE.
  - `start` while in RUN is ignored entirely: no queueing, no HI/LO change.
- MULT/MULTU:
  - The 64-bit product of `rs_data`×`rt_data` (signed / unsigned) is computed at acceptance and held in a pending register.
  - Counter loads `MULT_CYCLES`; state goes to RUN.
- DIV/DIVU:
  - Signed or unsigned divide. LO = quotient, HI = remainder, computed at acceptance into the pending register.
  - Counter loads `DIV_CYCLES`; state goes to RUN.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (`rt_data=0`): still occupies `DIV_CYCLES` with `busy=1`, but HI/LO are NOT written at completion.
- Completion:
  - Counter decrements once per cycle in RUN.
  - On the edge where it goes 1→0, the pending result is written to HI/LO (unless divide-by-zero) and state returns to IDLE.
- MTHI/MTLO:
  - Accepted in IDLE only.
  - `rs_data` is written to HI (MTHI) or LO (MTLO) on the same edge; the other register is unchanged; `busy` stays 0.
- NOP op with `start=1`: no effect.
- Operands may change freely after acceptance; the pending result is unaffected.
- Reset (`reset=0`), asynchronous, at any time including mid-RUN:
  - `busy=0`, `hi=0`, `lo=0`, counter and pending result cleared, state IDLE.
  - An in-flight operation is discarded.
  - The first edge after deassertion may accept a new op.

## Timing
- Reset values: `busy=0`, `hi=32'h0`, `lo=32'h0`.
- Multi-cycle op accepted at edge T:
  - `busy=1` from after edge T until edge T+N (N = `MULT_CYCLES` or `DIV_CYCLES`), i.e. exactly N cycles.
  - At edge T+N, `hi`/`lo` take the new value and `busy` falls together.
- Back-to-back: a new `start` at edge T+N is not accepted, since state is still RUN at that sample. The earliest next acceptance is edge T+N+1.
- MTHI/MTLO accepted at edge T: `hi`/`lo` updated after edge T; latency 1, no busy.
- `hi`/`lo` are registered outputs. They never show partial or pending results and change only at completion, MTHI/MTLO, or reset.

## Test plan
- Reset then MULT, `rs`=0xFFFFFFFF, `rt`=0x00000002 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat as MULTU → HI=0x00000001, LO=0xFFFFFFFE.
- DIV, `rs`=0xFFFFFFF9 (−7), `rt`=2 → after 10 busy cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 7/2 → LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → HI/LO hold those values one edge after each; `busy` never asserts. Then DIV by 0 → `busy` 10 cycles, HI/LO unchanged.
- MULT 3×4 accepted; during RUN pulse `start` with MTLO 0xDEADBEEF and with MULT 5×5 → both ignored; completion gives HI=0, LO=12. A `start` on the completion edge is also ignored; acceptance succeeds on the next edge.
- MULT 3×4 accepted, assert `reset`=0 asynchronously mid-RUN (between edges) → `busy`/`hi`/`lo` go to 0 immediately, with no late write after deassertion. A fresh MTHI 1 is accepted on the first edge after release.
